// File: rtl/ihex_stream_loader.sv
// Intel HEX stream parser writing packed, byte-masked words to a target memory.
// Define IHEX_CHECKSUM_EN to verify each record's 8-bit checksum.
module ihex_stream_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int WORD_BYTES = 1
) (
  input  logic                                       clk_74a,
  input  logic                                       reset_n,
  input  logic                                       in_valid,
  input  logic [7:0]                                 in_data,
  output logic                                       write_en,
  output logic [ADDR_WIDTH-$clog2(WORD_BYTES)-1:0]   write_addr,
  output logic [8*WORD_BYTES-1:0]                    write_data,
  output logic [WORD_BYTES-1:0]                      write_mask,
  output logic                                       done,
  output logic                                       error,
  output logic [15:0]                                record_count
);

  localparam int LOG2 = $clog2(WORD_BYTES);
  localparam int LW   = (LOG2 == 0) ? 1 : LOG2;
  localparam int WA   = ADDR_WIDTH - LOG2;

  typedef enum logic [2:0] {
    IDLE, LEN, OFFS, TYPE, DATA, CSUM, HALT
  } state_t;

  state_t state, state_n;

  logic [1:0]              nib;
  logic [3:0]              hi;
  logic [7:0]              len, rtype, idx;
  logic [15:0]             offs, data16;
  logic [31:0]             base;
  logic [8*WORD_BYTES-1:0] acc, acc_n;
  logic [WORD_BYTES-1:0]   mask, sel;
  logic [WA-1:0]           pend;

  logic                    hv;
  logic [3:0]              nv;
  logic [7:0]              bval;
  logic                    in_rec, colon, bad, step;
  logic [ADDR_WIDTH-1:0]   ba;
  logic [LW-1:0]           lane;
  logic                    csum_ok;

  always_comb begin
    hv = 1'b1;
    nv = 4'h0;
    unique case (1'b1)
      (in_data >= 8'h30 && in_data <= 8'h39): nv = in_data[3:0];
      (in_data >= 8'h41 && in_data <= 8'h46): nv = in_data[3:0] + 4'd9;
      (in_data >= 8'h61 && in_data <= 8'h66): nv = in_data[3:0] + 4'd9;
      default: hv = 1'b0;
    endcase
  end

  assign bval   = {hi, nv};
  assign in_rec = state inside {LEN, OFFS, TYPE, DATA, CSUM};
  assign colon  = in_valid && state == IDLE && in_data == 8'h3A;
  assign bad    = in_valid && in_rec && !hv;
  assign step   = in_valid && in_rec && hv;

  // Offset wraps within 16 bits before the base is added.
  assign ba   = ADDR_WIDTH'(base + {16'h0, offs + {8'h0, idx}});
  assign lane = ba[LW-1:0];

  always_comb begin
    acc_n = acc;
    for (int k = 0; k < WORD_BYTES; k++) begin
      sel[k] = (LOG2 == 0) || (lane == LW'(k));
      if (sel[k]) acc_n[8*k +: 8] = bval;
    end
  end

`ifdef IHEX_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      csum <= 8'h00;
    end else if (colon) begin
      csum <= 8'h00;
    end else if (step && nib[0]) begin
      csum <= csum + bval;
    end
  end

  assign csum_ok = (8'(csum + bval) == 8'h00);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (in_valid) begin
      unique case (state)
        IDLE: if (in_data == 8'h3A) state_n = LEN;
        HALT: state_n = HALT;
        LEN:  if (!hv) state_n = IDLE;
              else if (nib[0]) state_n = OFFS;
        OFFS: if (!hv) state_n = IDLE;
              else if (nib == 2'd3) state_n = TYPE;
        TYPE: if (!hv) state_n = IDLE;
              else if (nib[0]) state_n = (len == 8'h00) ? CSUM : DATA;
        DATA: if (!hv) state_n = IDLE;
              else if (nib[0] && idx + 8'd1 == len) state_n = CSUM;
        CSUM: if (!hv) state_n = IDLE;
              else if (nib[0]) state_n = (rtype == 8'h01) ? HALT : IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      write_en     <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      write_mask   <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      record_count <= 16'h0;
      nib          <= 2'd0;
      hi           <= 4'h0;
      len          <= 8'h0;
      rtype        <= 8'h0;
      idx          <= 8'h0;
      offs         <= 16'h0;
      data16       <= 16'h0;
      base         <= 32'h0;
      acc          <= '0;
      mask         <= '0;
      pend         <= '0;
    end else begin
      write_en <= 1'b0;
      if (colon) begin
        nib <= 2'd0;
        idx <= 8'h0;
      end else if (bad) begin
        error <= 1'b1;
        acc   <= '0;
        mask  <= '0;
      end else if (step) begin
        nib <= (nib[0] && state != OFFS) ? 2'd0 : nib + 2'd1;
        hi  <= nv;
        if (state == LEN && nib[0]) len <= bval;
        if (state == OFFS) offs <= {offs[11:0], nv};
        if (state == TYPE && nib[0]) begin
          rtype <= bval;
          idx   <= 8'h0;
        end
        if (state == DATA && nib[0]) begin
          data16 <= {data16[7:0], bval};
          idx    <= idx + 8'd1;
          if (rtype == 8'h00) begin
            if (sel[WORD_BYTES-1]) begin
              write_en   <= 1'b1;
              write_addr <= ba[ADDR_WIDTH-1:LOG2];
              write_data <= acc_n;
              write_mask <= mask | sel;
              acc        <= '0;
              mask       <= '0;
            end else begin
              acc  <= acc_n;
              mask <= mask | sel;
              pend <= ba[ADDR_WIDTH-1:LOG2];
            end
          end
        end
        if (state == CSUM && nib[0]) begin
          record_count <= record_count + 16'd1;
          if (mask != '0) begin
            write_en   <= 1'b1;
            write_addr <= pend;
            write_data <= acc;
            write_mask <= mask;
            acc        <= '0;
            mask       <= '0;
          end
          if (!csum_ok) error <= 1'b1;
          if (rtype == 8'h01) done <= 1'b1;
          if (rtype == 8'h02 || rtype == 8'h04) begin
            if (len != 8'h02) error <= 1'b1;
            else if (csum_ok && rtype == 8'h02) base <= {12'h0, data16, 4'h0};
            else if (csum_ok) base <= {data16, 16'h0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ihex_stream_loader.sv
// Scoreboard bench for ihex_stream_loader with 2-byte words and 17-bit addresses.
module tb_ihex_stream_loader;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        write_en;
  logic [15:0] write_addr;
  logic [15:0] write_data;
  logic [1:0]  write_mask;
  logic        done, error;
  logic [15:0] record_count;

  ihex_stream_loader #(.ADDR_WIDTH(17), .WORD_BYTES(2)) dut (
    .clk_74a(clk_74a), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_mask(write_mask),
    .done(done), .error(error), .record_count(record_count)
  );

  always #5 clk_74a = ~clk_74a;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  m;
  } wr_t;

  wr_t sbq[$];
  int  n_vec = 0;
  int  n_err = 0;
  logic [31:0] mbase = 32'h0;
  logic [15:0] exp_cnt = 16'h0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_74a) begin
    if (reset_n && write_en) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", {write_addr, write_data}, 64'h0);
      end else begin
        wr_t e;
        logic [15:0] bm;
        e  = sbq.pop_front();
        bm = {{8{e.m[1]}}, {8{e.m[0]}}};
        chk("waddr", write_addr, e.a);
        chk("wmask", write_mask, e.m);
        chk("wdata", write_data & bm, e.d & bm);
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] m);
    wr_t e;
    e.a = a; e.d = d; e.m = m;
    sbq.push_back(e);
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk_74a);
    in_valid = 1'b1;
    in_data  = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_74a);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    idle(3);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] v, input bit lc);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    return (lc ? 8'h57 : 8'h37) + {4'h0, v};
  endfunction

  task automatic send_hex8(input logic [7:0] b, input bit lc);
    send_char(hexc(b[7:4], lc));
    send_char(hexc(b[3:0], lc));
  endtask

  // Builds a valid type-00 record and predicts its writes independently.
  task automatic data_rec(input logic [15:0] off, input int n, input bit lc);
    logic [7:0]  d[$];
    logic [7:0]  sum;
    logic [16:0] a;
    logic [15:0] acc, pend;
    logic [1:0]  m;
    sum = 8'(n) + off[15:8] + off[7:0];
    acc = 16'h0; m = 2'b00; pend = 16'h0;
    for (int i = 0; i < n; i++) begin
      d.push_back(8'($urandom_range(0, 255)));
      sum = sum + d[i];
      a = 17'(mbase + {16'h0, 16'(off + 16'(i))});
      if (a[0]) acc[15:8] = d[i]; else acc[7:0] = d[i];
      m[a[0]] = 1'b1;
      if (a[0]) begin
        push(a[16:1], acc, m);
        acc = 16'h0; m = 2'b00;
      end else begin
        pend = a[16:1];
      end
    end
    if (m != 2'b00) push(pend, acc, m);
    send_char(8'h3A);
    send_hex8(8'(n), lc);
    send_hex8(off[15:8], lc);
    send_hex8(off[7:0], lc);
    send_hex8(8'h00, lc);
    for (int i = 0; i < n; i++) send_hex8(d[i], lc);
    send_hex8(8'h00 - sum, lc);
    send_char(8'h0D);
    send_char(8'h0A);
    idle(3);
    exp_cnt++;
  endtask

  task automatic status(input string tag, input logic e, input logic dn);
    chk({tag, "_err"}, error, e);
    chk({tag, "_done"}, done, dn);
    chk({tag, "_cnt"}, record_count, exp_cnt);
    chk({tag, "_sb"}, sbq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_74a);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #2;
    chk("rst_we", write_en, 1'b0);
    chk("rst_out", {write_addr, write_data, write_mask}, 0);
    chk("rst_flags", {done, error, record_count}, 0);
    @(negedge clk_74a);
    reset_n = 1'b1;
    mbase   = 32'h0;
    exp_cnt = 16'h0;
  endtask

  initial begin
    repeat (2) @(negedge clk_74a);
    chk("por_out", {write_en, write_addr, write_data, write_mask}, 0);
    chk("por_flags", {done, error, record_count}, 0);
    reset_n = 1'b1;

    push(16'h0008, 16'h2211, 2'b11);
    push(16'h0009, 16'h0033, 2'b01);
    send_str(":0300100011223387\r\n");
    exp_cnt = 16'd1;
    status("t1", 1'b0, 1'b0);

    data_rec(16'hFFFF, 3, 1'b0);
    data_rec(16'h0041, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      data_rec(16'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 9), i[0]);
    status("rand", 1'b0, 1'b0);

    send_str(":020000040001F9\r\n");
    push(16'h8000, 16'h0055, 2'b01);
    send_str(":0100000055AA\r\n");
    exp_cnt += 2;
    status("ext04", 1'b0, 1'b0);
    send_str(":020000021000EC");
    push(16'h8002, 16'h0066, 2'b01);
    send_str(":010004006695");
    exp_cnt += 2;
    status("seg02", 1'b0, 1'b0);
    send_str(":0100000401FA");
    push(16'h8000, 16'h0055, 2'b01);
    send_str(":0100000055AA");
    exp_cnt += 2;
    status("badlen", 1'b1, 1'b0);

    do_reset();
    push(16'h0000, 16'h0055, 2'b01);
    send_str(":0100000055AB");
    exp_cnt = 16'd1;
`ifdef IHEX_CHECKSUM_EN
    status("csum", 1'b1, 1'b0);
`else
    status("csum", 1'b0, 1'b0);
`endif

    do_reset();
    send_str(":01G0");
    status("badhex", 1'b1, 1'b0);
    push(16'h0010, 16'h0077, 2'b01);
    send_str(":010020007768");
    exp_cnt = 16'd1;
    status("recover", 1'b1, 1'b0);

    do_reset();
    send_str(":00000001FF\r\n");
    exp_cnt = 16'd1;
    status("eof", 1'b0, 1'b1);
    send_str(":0100000055AA\r\n");
    status("halt", 1'b0, 1'b1);

    do_reset();
    send_str(":020000040001F9");
    exp_cnt = 16'd1;
    status("pre", 1'b0, 1'b0);
    send_str(":0200");
    do_reset();
    push(16'h0000, 16'h0055, 2'b01);
    send_str(":0100000055AA");
    exp_cnt = 16'd1;
    status("post", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
